alu_iterative: RTL and testbench
================================

Name: alu_iterative

Overview:
- Parametrised successor to the team's 2-bit combinational MIPS ALU: a WIDTH-bit ALU with registered outputs and a start/ready/done handshake.
- Extends the op set with OR, XOR, SLT/SLTU and shifts, all single-cycle.
- Adds iterative unsigned multiply and divide (one bit per clock) that drive HI/LO style outputs.
- Sits in the execute stage of the multi-cycle datapath; the controller stalls on ready.

Parameters:
- WIDTH, 32, operand/result width; must be >= 4 and a power of two.
- SHAMT_W, $clog2(WIDTH), shift-amount bits taken from b.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- alu_control  in  4  operation code, sampled at accept
- a  in  WIDTH  operand A, sampled at accept
- b  in  WIDTH  operand B, sampled at accept
- ready  out  1  block can accept a request this cycle
- done  out  1  one-cycle pulse; result, result_hi, zero and overflow are valid
- result  out  WIDTH  primary result (LO / quotient)
- result_hi  out  WIDTH  MULU high half / DIVU remainder; 0 for other ops
- zero  out  1  result == 0
- overflow  out  1  signed overflow, ADD/SUB only

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE, ready=1, done=0, result=0, result_hi=0, zero=0, overflow=0. Iteration state is cleared and any in-flight op is abandoned with no done pulse.
- Accept condition: start && ready at a rising edge. start while ready=0 is ignored, not queued.
- Op codes:
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 AND
  - 3 NOR
  - 4 OR
  - 5 XOR
  - 6 SLT (signed, result 1/0)
  - 7 SLTU
  - 8 SLL b-shift? no: a << b[SHAMT_W-1:0]
  - 9 SRL a >> b[SHAMT_W-1:0]
  - 10 SRA (arithmetic) a >>> b[SHAMT_W-1:0]
  - 11 MULU {result_hi,result} = a*b unsigned
  - 12 DIVU result=a/b, result_hi=a%b
  - 13-15 reserved: single-cycle, result=0, zero=1
- Codes 0-10 and 13-15 are single-cycle: outputs register at the accept edge, done=1 in the next cycle (latency 1). ready stays 1, so back-to-back accepts every cycle are legal.
- Codes 11-12 are iterative. FSM IDLE -> MUL or DIV -> FIN -> IDLE:
  - Accept edge: load operands, set a step counter to WIDTH, ready goes 0.
  - MUL: shift-add, one multiplier bit per cycle.
  - DIV: restoring, one quotient bit per cycle.
  - Each cycle decrements the counter. When the counter reaches 0 after WIDTH step cycles, enter FIN.
  - FIN: write outputs and pulse done, return to IDLE with ready=1.
  - done appears WIDTH+1 cycles after accept. A new request is accepted in the done cycle.
- Outputs hold their values between done pulses. done is never high for two consecutive cycles from one request.
- Width rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - overflow = operand signs equal (ADD) or different (SUB) and result sign differs from a's sign.
  - overflow=0 and result_hi=0 for all non-MUL/DIV ops.
- DIVU by zero: result = all ones, result_hi = a, still WIDTH+1 latency.
- Shift amount: only the low SHAMT_W bits of b are used; higher bits are ignored.
- zero always reflects the registered result (LO) only.

Decomposition:
- Shared package alu_pkg: op-code localparams (ALU_ADD ... ALU_DIVU), FSM state encodings (S_IDLE, S_MUL, S_DIV, S_FIN).
- Reused by the controller's alu_control decoder.
- One sub-module is natural: alu_muldiv_seq.
  - Holds the iterative multiply/divide datapath and step counter.
  - Handshake to the top: go / busy / fin, plus lo/hi outputs.
- The top holds the single-cycle combinational ops, output registers and the handshake FSM.

Test Plan:
- WIDTH=32, reset released; ADD a=1 b=3 -> next cycle done=1, result=4, zero=0. SUB a=1 b=3 -> result=0xFFFFFFFE, overflow=0. AND -> 1. NOR -> 0xFFFFFFFC.
- ADD a=0x7FFFFFFF b=1 -> result=0x80000000, overflow=1. SUB a=5 b=5 -> zero=1. SLT a=0xFFFFFFFF b=1 -> 1. SLTU same operands -> 0. SRA a=0x80000000 b=0x24 (shamt 4) -> 0xF8000000.
- MULU a=0xFFFFFFFF b=2 -> ready low for 33 cycles, done exactly 33 cycles after accept, result=0xFFFFFFFE, result_hi=1. start pulses while busy are ignored with no extra done.
- DIVU a=100 b=7 -> result=14, result_hi=2. DIVU a=9 b=0 -> result=0xFFFFFFFF, result_hi=9. Back-to-back ADD accepted in the DIVU done cycle completes one cycle later.
- Assert reset 10 cycles into a MULU -> outputs 0 immediately, ready=1, no done pulse. Next ADD a=2 b=2 -> result=4.
- WIDTH=8 instance: MULU a=0xFF b=0xFF -> done at 9 cycles, result=0x01, result_hi=0xFE. SLL b=0x0B (shamt 3), a=1 -> 0x08.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes and handshake FSM state encodings.
// Used by the iterative ALU and by the controller's alu_control decoder.
// No logic here: constants and types only.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_NOR  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_MULU = 4'd11;
  localparam logic [3:0] ALU_DIVU = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per clock.
// Latency: WIDTH step cycles after i_go; o_fin is high during the last step cycle.
// Backpressure: none internally; i_go must only be raised while o_busy is low.
module alu_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_go,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_fin,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_is_div;
  logic [WIDTH-1:0] r_hi;   // product high half / partial remainder
  logic [WIDTH-1:0] r_lo;   // multiplier shifting out + product low / dividend out + quotient in
  logic [WIDTH-1:0] r_opb;  // multiplicand / divisor

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_diff;

  // One step of each algorithm; the extra top bit carries the add carry / subtract borrow.
  always_comb begin
    w_mul_sum   = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opb}) : {1'b0, r_hi};
    w_div_shift = {r_hi, r_lo[WIDTH-1]};
    w_div_diff  = w_div_shift - {1'b0, r_opb};
  end

  // Load on go, then step once per clock until the counter drains. A zero divisor
  // never borrows, so it naturally yields quotient all-ones and remainder = dividend.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt    <= '0;
      r_is_div <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_opb    <= '0;
    end else if (i_go) begin
      r_cnt    <= CNT_W'(WIDTH);
      r_is_div <= i_is_div;
      r_hi     <= '0;
      r_lo     <= i_is_div ? i_a : i_b;
      r_opb    <= i_is_div ? i_b : i_a;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
      if (r_is_div) begin
        if (!w_div_diff[WIDTH]) begin
          r_hi <= w_div_diff[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b1};
        end else begin
          r_hi <= w_div_shift[WIDTH-1:0];
          r_lo <= {r_lo[WIDTH-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_mul_sum[WIDTH:1];
        r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign o_busy = (r_cnt != '0);
  assign o_fin  = (r_cnt == CNT_W'(1));
  assign o_lo   = r_lo;
  assign o_hi   = r_hi;

endmodule

// File: rtl/alu_iterative.sv
// WIDTH-bit ALU with registered outputs; single-cycle ops plus iterative MULU/DIVU.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles for MULU/DIVU.
// Backpressure: o_ready low while MULU/DIVU runs; i_start is ignored (not queued) then.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [3:0]       i_alu_control,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_zero,
  output logic             o_overflow
);

  state_t             r_state;
  state_t             w_next_state;
  logic               w_ready;
  logic               w_accept;
  logic               w_is_multi;
  logic               w_go;
  logic               w_seq_busy;
  logic               w_seq_fin;
  logic [WIDTH-1:0]   w_seq_lo;
  logic [WIDTH-1:0]   w_seq_hi;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;

  logic               r_done;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_result_hi;
  logic               r_zero;
  logic               r_overflow;

  assign w_shamt    = i_b[SHAMT_W-1:0];
  assign w_sum      = i_a + i_b;
  assign w_diff     = i_a - i_b;
  assign w_is_multi = (i_alu_control == ALU_MULU) || (i_alu_control == ALU_DIVU);
  assign w_accept   = i_start && w_ready;

  // Single-cycle result and signed overflow for the op presented this cycle.
  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    case (i_alu_control)
      ALU_ADD: begin
        w_res = w_sum;
        w_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_res = w_diff;
        w_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
      end
      ALU_AND:  w_res = i_a & i_b;
      ALU_NOR:  w_res = ~(i_a | i_b);
      ALU_OR:   w_res = i_a | i_b;
      ALU_XOR:  w_res = i_a ^ i_b;
      ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
      ALU_SLL:  w_res = i_a << w_shamt;
      ALU_SRL:  w_res = i_a >> w_shamt;
      ALU_SRA:  w_res = $signed(i_a) >>> w_shamt;
      default:  w_res = '0;  // reserved codes; MULU/DIVU take the iterative path
    endcase
  end

  alu_muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_go     (w_go),
    .i_is_div (i_alu_control == ALU_DIVU),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (w_seq_busy),
    .o_fin    (w_seq_fin),
    .o_lo     (w_seq_lo),
    .o_hi     (w_seq_hi)
  );

  // Handshake FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // Next state: leave IDLE only for MULU/DIVU; FIN is a single write-back cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (i_alu_control == ALU_MULU)) w_next_state = S_MUL;
        else if (w_accept && (i_alu_control == ALU_DIVU)) w_next_state = S_DIV;
      end
      S_MUL, S_DIV: if (w_seq_fin) w_next_state = S_FIN;
      S_FIN:        w_next_state = S_IDLE;
      default:      w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs: ready only when idle, and kick the sequencer on an iterative accept.
  always_comb begin
    w_ready = (r_state == S_IDLE) && !w_seq_busy;
    w_go    = w_accept && w_is_multi;
  end

  // Output registers: written by a single-cycle accept or by the FIN write-back, else held.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_done      <= 1'b0;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (r_state == S_FIN) begin
      r_done      <= 1'b1;
      r_result    <= w_seq_lo;
      r_result_hi <= w_seq_hi;
      r_zero      <= (w_seq_lo == '0);
      r_overflow  <= 1'b0;
    end else if (w_accept && !w_is_multi) begin
      r_done      <= 1'b1;
      r_result    <= w_res;
      r_result_hi <= '0;
      r_zero      <= (w_res == '0);
      r_overflow  <= w_ovf;
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_ready     = w_ready;
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_result_hi = r_result_hi;
  assign o_zero      = r_zero;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_alu_iterative.sv
// Directed bench for alu_iterative at WIDTH=32 and WIDTH=8.
// Expected values are hand-computed constants.
// Outputs are sampled 1 time unit after each rising edge.
module tb_alu_iterative;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  ctl;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        done;
  logic [31:0] res;
  logic [31:0] res_hi;
  logic        zero;
  logic        ovf;

  logic        start8;
  logic [3:0]  ctl8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        ready8;
  logic        done8;
  logic [7:0]  res8;
  logic [7:0]  hi8;
  logic        zero8;
  logic        ovf8;

  int n_pass;
  int n_total;
  int n_fail;

  alu_iterative #(.WIDTH(32)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start),
    .i_alu_control (ctl),
    .i_a           (a),
    .i_b           (b),
    .o_ready       (ready),
    .o_done        (done),
    .o_result      (res),
    .o_result_hi   (res_hi),
    .o_zero        (zero),
    .o_overflow    (ovf)
  );

  alu_iterative #(.WIDTH(8)) dut8 (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_start       (start8),
    .i_alu_control (ctl8),
    .i_a           (a8),
    .i_b           (b8),
    .o_ready       (ready8),
    .o_done        (done8),
    .o_result      (res8),
    .o_result_hi   (hi8),
    .o_zero        (zero8),
    .o_overflow    (ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one request for a single clock; returns 1 unit after the accept edge.
  task automatic op32(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1;
    ctl   = op;
    a     = va;
    b     = vb;
    tick;
    start = 1'b0;
  endtask

  // Wait for done on the 32-bit instance; optionally poke start while busy.
  task automatic wait32(input bit poke, output int lat, output int rlow);
    lat  = 0;
    rlow = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (ready !== 1'b1) rlow++;
      start = poke && (lat >= 5) && (lat < 8);
      tick;
      lat++;
    end
    start = 1'b0;
  endtask

  initial begin
    int lat;
    int rlow;
    int ndone;
    n_pass  = 0;
    n_total = 0;
    n_fail  = 0;
    reset   = 1'b0;
    start   = 1'b0;
    ctl     = 4'd0;
    a       = '0;
    b       = '0;
    start8  = 1'b0;
    ctl8    = 4'd0;
    a8      = '0;
    b8      = '0;

    #1 reset = 1'b1;
    #2;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_result", res, 0);
    chk("rst_result_hi", res_hi, 0);
    chk("rst_zero", zero, 0);
    chk("rst_overflow", ovf, 0);
    tick;
    tick;
    reset = 1'b0;
    tick;

    op32(4'd0, 32'd1, 32'd3);
    chk("add_done", done, 1);
    chk("add_result", res, 32'd4);
    chk("add_zero", zero, 0);
    chk("add_ovf", ovf, 0);
    tick;
    chk("add_done_pulse", done, 0);
    chk("add_hold", res, 32'd4);

    op32(4'd1, 32'd1, 32'd3);
    chk("sub_result", res, 32'hFFFF_FFFE);
    chk("sub_ovf", ovf, 0);
    op32(4'd2, 32'd1, 32'd3);
    chk("and_done", done, 1);
    chk("and_result", res, 32'd1);
    op32(4'd3, 32'd1, 32'd3);
    chk("nor_result", res, 32'hFFFF_FFFC);
    op32(4'd4, 32'd1, 32'd6);
    chk("or_result", res, 32'd7);
    op32(4'd5, 32'd5, 32'd3);
    chk("xor_result", res, 32'd6);

    op32(4'd0, 32'h7FFF_FFFF, 32'd1);
    chk("add_ovf_result", res, 32'h8000_0000);
    chk("add_ovf_flag", ovf, 1);
    op32(4'd1, 32'd5, 32'd5);
    chk("sub_zero_flag", zero, 1);
    chk("sub_zero_ovf", ovf, 0);
    op32(4'd1, 32'h8000_0000, 32'd1);
    chk("sub_ovf_result", res, 32'h7FFF_FFFF);
    chk("sub_ovf_flag", ovf, 1);
    op32(4'd6, 32'hFFFF_FFFF, 32'd1);
    chk("slt_result", res, 32'd1);
    op32(4'd7, 32'hFFFF_FFFF, 32'd1);
    chk("sltu_result", res, 32'd0);
    chk("sltu_zero", zero, 1);
    op32(4'd10, 32'h8000_0000, 32'h24);
    chk("sra_result", res, 32'hF800_0000);
    op32(4'd9, 32'h8000_0000, 32'h24);
    chk("srl_result", res, 32'h0800_0000);
    op32(4'd8, 32'd1, 32'h21);
    chk("sll_result", res, 32'd2);
    op32(4'd14, 32'h1234, 32'h5678);
    chk("rsvd_result", res, 32'd0);
    chk("rsvd_zero", zero, 1);
    chk("rsvd_hi", res_hi, 0);

    op32(4'd11, 32'hFFFF_FFFF, 32'd2);
    chk("mul_ready_low", ready, 0);
    wait32(1'b1, lat, rlow);
    chk("mul_latency", lat, 33);
    chk("mul_ready_cycles", rlow, 33);
    chk("mul_lo", res, 32'hFFFF_FFFE);
    chk("mul_hi", res_hi, 32'd1);
    chk("mul_ovf", ovf, 0);
    chk("mul_ready_back", ready, 1);
    ndone = 0;
    repeat (40) begin
      tick;
      if (done === 1'b1) ndone++;
    end
    chk("mul_no_extra_done", ndone, 0);

    op32(4'd12, 32'd100, 32'd7);
    wait32(1'b0, lat, rlow);
    chk("div_latency", lat, 33);
    chk("div_quot", res, 32'd14);
    chk("div_rem", res_hi, 32'd2);
    op32(4'd0, 32'd2, 32'd3);
    chk("b2b_done", done, 1);
    chk("b2b_result", res, 32'd5);
    chk("b2b_hi", res_hi, 0);

    op32(4'd12, 32'd9, 32'd0);
    wait32(1'b0, lat, rlow);
    chk("div0_latency", lat, 33);
    chk("div0_quot", res, 32'hFFFF_FFFF);
    chk("div0_rem", res_hi, 32'd9);

    op32(4'd11, 32'hFFFF_FFFF, 32'd2);
    repeat (9) tick;
    reset = 1'b1;
    #1;
    chk("mid_rst_result", res, 0);
    chk("mid_rst_hi", res_hi, 0);
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_done", done, 0);
    tick;
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      tick;
      if (done === 1'b1) ndone++;
    end
    chk("mid_rst_no_done", ndone, 0);
    op32(4'd0, 32'd2, 32'd2);
    chk("post_rst_add", res, 32'd4);

    start8 = 1'b1;
    ctl8   = 4'd11;
    a8     = 8'hFF;
    b8     = 8'hFF;
    tick;
    start8 = 1'b0;
    lat    = 0;
    while (done8 !== 1'b1 && lat < 100) begin
      tick;
      lat++;
    end
    chk("w8_mul_latency", lat, 9);
    chk("w8_mul_lo", res8, 32'h01);
    chk("w8_mul_hi", hi8, 32'hFE);
    start8 = 1'b1;
    ctl8   = 4'd8;
    a8     = 8'h01;
    b8     = 8'h0B;
    tick;
    start8 = 1'b0;
    chk("w8_sll_done", done8, 1);
    chk("w8_sll_result", res8, 32'h08);
    chk("w8_sll_hi", hi8, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
